// File: rtl/pid_seq.sv
// Multi-cycle PID term sequencer: saturates one error sample per request, then computes
// P, I and D terms in successive states over one shared multiplier and one shared adder.
module pid_seq #(
    parameter int unsigned P_COEFF = 3,
    parameter int unsigned D_COEFF = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               err_vld_i,
    input  logic signed [15:0] error_i,
    input  logic               clr_I_i,
    output logic               busy_o,
    output logic               pid_vld_o,
    output logic signed [13:0] P_term_o,
    output logic signed [11:0] I_term_o,
    output logic signed [12:0] D_term_o,
    output logic signed [15:0] pid_o
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StSat   = 3'd1;
    localparam logic [2:0] StPterm = 3'd2;
    localparam logic [2:0] StIterm = 3'd3;
    localparam logic [2:0] StDterm = 3'd4;
    localparam logic [2:0] StSum   = 3'd5;

    localparam logic signed [13:0] PCoeff = 14'(P_COEFF);
    localparam logic signed [13:0] DCoeff = 14'(D_COEFF);

    logic [2:0]         state_q, state_d;
    logic [15:0]        err_reg_q, err_reg_d;
    logic [9:0]         err_sat_q, err_sat_d;
    logic [15:0]        integ_q, integ_d;
    logic [9:0]         prev_err_q, prev_err_d;
    logic signed [13:0] p_term_q, p_term_d;
    logic signed [11:0] i_term_q, i_term_d;
    logic signed [12:0] d_term_q, d_term_d;
    logic signed [15:0] pid_q, pid_d;
    logic               pid_vld_q, pid_vld_d;

    logic [9:0]         sat_val;
    logic [10:0]        d_diff;
    logic [6:0]         d_sat;
    logic signed [13:0] mul_a, mul_b, mul_p;
    logic signed [15:0] add_a, add_b, add_c, add_s;
    logic               integ_ovf;

    // 16 -> 10 bit saturation of the captured sample
    always_comb begin
        if (!err_reg_q[15] && (|err_reg_q[14:9])) begin
            sat_val = 10'h1FF;
        end else if (err_reg_q[15] && !(&err_reg_q[14:9])) begin
            sat_val = 10'h200;
        end else begin
            sat_val = err_reg_q[9:0];
        end
    end

    // Derivative difference at 11 bits, clamped to 7 bits
    always_comb begin
        d_diff = {err_sat_q[9], err_sat_q} - {prev_err_q[9], prev_err_q};
        if (!d_diff[10] && (|d_diff[9:6])) begin
            d_sat = 7'h3F;
        end else if (d_diff[10] && !(&d_diff[9:6])) begin
            d_sat = 7'h40;
        end else begin
            d_sat = d_diff[6:0];
        end
    end

    // Shared multiplier: err_sat * P in PTERM, D_sat * D in DTERM
    always_comb begin
        if (state_q == StDterm) begin
            mul_a = {{7{d_sat[6]}}, d_sat};
            mul_b = DCoeff;
        end else begin
            mul_a = {{4{err_sat_q[9]}}, err_sat_q};
            mul_b = PCoeff;
        end
        mul_p = mul_a * mul_b;
    end

    // Shared adder: integrator update in ITERM, final P + I + D in SUM
    always_comb begin
        add_a = '0;
        add_b = '0;
        add_c = '0;
        if (state_q == StIterm) begin
            add_a = integ_q;
            add_b = {{6{err_sat_q[9]}}, err_sat_q};
        end else if (state_q == StSum) begin
            add_a = {{2{p_term_q[13]}}, p_term_q};
            add_b = {{4{i_term_q[11]}}, i_term_q};
            add_c = {{3{d_term_q[12]}}, d_term_q};
        end
        add_s = add_a + add_b + add_c;
    end

    assign integ_ovf = (integ_q[15] == err_sat_q[9]) && (add_s[15] != integ_q[15]);

    always_comb begin
        state_d    = state_q;
        err_reg_d  = err_reg_q;
        err_sat_d  = err_sat_q;
        integ_d    = integ_q;
        prev_err_d = prev_err_q;
        p_term_d   = p_term_q;
        i_term_d   = i_term_q;
        d_term_d   = d_term_q;
        pid_d      = pid_q;
        pid_vld_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (err_vld_i) begin
                    err_reg_d = error_i;
                    state_d   = StSat;
                end
            end
            StSat: begin
                err_sat_d = sat_val;
                state_d   = StPterm;
            end
            StPterm: begin
                p_term_d = mul_p;
                state_d  = StIterm;
            end
            StIterm: begin
                if (clr_I_i) begin
                    integ_d  = '0;
                    i_term_d = '0;
                end else begin
                    integ_d  = integ_ovf ? integ_q : add_s;
                    i_term_d = integ_d[15:4];
                end
                state_d = StDterm;
            end
            StDterm: begin
                d_term_d   = mul_p[12:0];
                prev_err_d = err_sat_q;
                state_d    = StSum;
            end
            StSum: begin
                pid_d     = add_s;
                pid_vld_d = 1'b1;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Integrator clear applies in every state, not only ITERM
        if (clr_I_i) begin
            integ_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            err_reg_q  <= '0;
            err_sat_q  <= '0;
            integ_q    <= '0;
            prev_err_q <= '0;
            p_term_q   <= '0;
            i_term_q   <= '0;
            d_term_q   <= '0;
            pid_q      <= '0;
            pid_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_reg_q  <= err_reg_d;
            err_sat_q  <= err_sat_d;
            integ_q    <= integ_d;
            prev_err_q <= prev_err_d;
            p_term_q   <= p_term_d;
            i_term_q   <= i_term_d;
            d_term_q   <= d_term_d;
            pid_q      <= pid_d;
            pid_vld_q  <= pid_vld_d;
        end
    end

    assign busy_o    = (state_q != StIdle);
    assign pid_vld_o = pid_vld_q;
    assign P_term_o  = p_term_q;
    assign I_term_o  = i_term_q;
    assign D_term_o  = d_term_q;
    assign pid_o     = pid_q;

endmodule
